// File: rtl/prefix_pkg.sv
// Carry-flag encoding and the prefix combine operator shared by the adder levels.
package prefix_pkg;

  localparam logic [1:0] FLAG_KILL = 2'b00;
  localparam logic [1:0] FLAG_GEN  = 2'b11;
  localparam logic [1:0] FLAG_PROP = 2'b01;

  // Both mixed encodings (01 and 10) mean propagate.
  function automatic logic flag_is_prop(input logic [1:0] f);
    return (f == FLAG_PROP) || (f == ~FLAG_PROP);
  endfunction

  // A propagating upper group inherits the lower group's flag; kill/generate stick.
  function automatic logic [1:0] flag_combine(input logic [1:0] hi, input logic [1:0] lo);
    return flag_is_prop(hi) ? lo : hi;
  endfunction

endpackage

// File: rtl/prefix_level.sv
// One Kogge-Stone style prefix level: position j looks back DISTANCE positions.
module prefix_level
  import prefix_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DISTANCE = 1
) (
  input  logic [WIDTH:0][1:0] flags_prev,
  output logic [WIDTH:0][1:0] flags_next
);

  for (genvar j = 0; j <= WIDTH; j++) begin : g_pos
    if (j >= DISTANCE) begin : g_combine
      assign flags_next[j] = flag_combine(flags_prev[j], flags_prev[j - DISTANCE]);
    end else begin : g_pass
      assign flags_next[j] = flags_prev[j];
    end
  end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Parallel-prefix adder/subtractor with a stall-as-a-whole valid/ready pipeline.
module pipelined_prefix_adder
  import prefix_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned LEVELS = $clog2(WIDTH + 1);
  localparam int unsigned S      = 1 + (LEVELS + REG_EVERY - 1) / REG_EVERY;

  logic                   advance;
  logic [S-1:0]           valid_q;
  logic [WIDTH-1:0]       p_q [S];
  logic [WIDTH-1:0]       b_eff;
  logic [WIDTH:0][1:0]    flags_in;
  logic [WIDTH:0][1:0]    flags0_q;
  logic [WIDTH:0][1:0]    lvl [LEVELS+1];
  logic [WIDTH:0]         carry;
  logic [WIDTH-1:0]       sum;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance || reset;
  assign out_valid = valid_q[S-1];

  // Build the input flag vector: position 0 is the effective carry-in.
  always_comb begin
    b_eff       = in_sub ? ~in_b : in_b;
    flags_in    = '0;
    flags_in[0] = (in_sub || in_cin) ? FLAG_GEN : FLAG_KILL;
    for (int i = 0; i < WIDTH; i++) begin
      flags_in[i+1] = {in_a[i], b_eff[i]};
    end
  end

  // Valid bits shift with the pipeline; bubbles travel like beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (advance) begin
      valid_q <= {valid_q[S-2:0], in_valid};
    end
  end

  // Stage-0 flags and the propagate vector that rides along to the output.
  always_ff @(posedge clk) begin
    if (advance) begin
      flags0_q <= flags_in;
      p_q[0]   <= in_a ^ b_eff;
      for (int s = 1; s < S; s++) begin
        p_q[s] <= p_q[s-1];
      end
    end
  end

  assign lvl[0] = flags0_q;

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    logic [WIDTH:0][1:0] comb_flags;

    prefix_level #(
      .WIDTH    (WIDTH),
      .DISTANCE (32'(1) << k)
    ) u_level (
      .flags_prev (lvl[k]),
      .flags_next (comb_flags)
    );

    if (((k + 1) % REG_EVERY == 0) || (k == LEVELS - 1)) begin : g_reg
      logic [WIDTH:0][1:0] flags_q;

      // Pipeline register closing this group of levels.
      always_ff @(posedge clk) begin
        if (advance) begin
          flags_q <= comb_flags;
        end
      end

      assign lvl[k+1] = flags_q;
    end else begin : g_comb
      assign lvl[k+1] = comb_flags;
    end
  end

  // Resolved flags are carries into each bit; form the result from the last stage.
  always_comb begin
    carry = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      carry[i] = (lvl[LEVELS][i] == FLAG_GEN);
    end
    sum      = p_q[S-1] ^ carry[WIDTH-1:0];
    out_sum  = sum;
    out_cout = carry[WIDTH];
    out_ovf  = carry[WIDTH] ^ carry[WIDTH-1];
    out_zero = (sum == '0);
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed bench for pipelined_prefix_adder (32-bit/REG_EVERY=2 and 8-bit/REG_EVERY=3).
module tb_pipelined_prefix_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_sub, in_cin;
  logic [31:0] in_a, in_b, out_sum;
  logic        out_valid, out_ready, out_cout, out_ovf, out_zero;

  logic        n_in_valid, n_in_ready, n_in_sub, n_in_cin;
  logic [7:0]  n_in_a, n_in_b, n_out_sum;
  logic        n_out_valid, n_out_ready, n_out_cout, n_out_ovf, n_out_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipelined_prefix_adder #(.WIDTH(32), .REG_EVERY(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  pipelined_prefix_adder #(.WIDTH(8), .REG_EVERY(3)) u_narrow (
    .clk(clk), .reset(reset),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_a(n_in_a), .in_b(n_in_b), .in_sub(n_in_sub), .in_cin(n_in_cin),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_sum(n_out_sum), .out_cout(n_out_cout), .out_ovf(n_out_ovf), .out_zero(n_out_zero)
  );

  // Behavioral reference: {cout, ovf, zero, sum}.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic cin);
    logic [31:0] be;
    logic [32:0] r;
    logic        ov;
    be = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, be} + 33'(sub | cin);
    ov = (a[31] == be[31]) && (r[31] != a[31]);
    return {r[32], ov, (r[31:0] == 32'h0), r[31:0]};
  endfunction

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b1; in_a = 32'h1; in_b = 32'h2; in_sub = 1'b0; in_cin = 1'b0;
    out_ready = 1'b0;
    n_in_valid = 1'b1; n_in_a = 8'h1; n_in_b = 8'h1; n_in_sub = 1'b0; n_in_cin = 1'b0;
    n_out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (n_in_ready !== 1'b1) begin errors++; $display("FAIL reset_narrow_in_ready: got %b expected 1", n_in_ready); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    reset = 1'b0; in_valid = 1'b0; n_in_valid = 1'b0; out_ready = 1'b1;
    begin
      int hits;
      hits = 0;
      for (int c = 0; c < 8; c++) begin
        if (out_valid !== 1'b0 || n_out_valid !== 1'b0) hits++;
        @(posedge clk); #1;
      end
      checks++;
      if (hits != 0) begin errors++; $display("FAIL reset_no_capture: got %0d valid cycles expected 0", hits); end
    end
  endtask

  task automatic test_directed;
    logic [31:0] va [9];
    logic [31:0] vb [9];
    logic [31:0] vs [9];
    logic        vsub [9];
    logic        vcin [9];
    logic        vc [9];
    logic        vo [9];
    logic        vz [9];
    int          lat;
    va   = '{32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'h7FFFFFFF, 32'h00000005,
             32'h00000000, 32'h00000010, 32'h80000000, 32'hAAAAAAAA};
    vb   = '{32'h00000001, 32'h00000001, 32'h9ABCDEF0, 32'h00000001, 32'h00000005,
             32'h00000001, 32'h00000003, 32'h80000000, 32'h55555555};
    vsub = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vcin = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vs   = '{32'h00000000, 32'h7FFFFFFF, 32'hACF13569, 32'h80000000, 32'h00000000,
             32'hFFFFFFFF, 32'h0000000D, 32'h00000000, 32'h00000000};
    vc   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vo   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vz   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_sub = vsub[i]; in_cin = vcin[i];
      lat = 0;
      do begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat++;
      end while (out_valid !== 1'b1 && lat < 12);
      checks++;
      if (lat != 4) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 4", i, lat); end
      checks++;
      if (out_sum !== vs[i]) begin errors++; $display("FAIL dir%0d_sum: got %h expected %h", i, out_sum, vs[i]); end
      checks++;
      if (out_cout !== vc[i]) begin errors++; $display("FAIL dir%0d_cout: got %b expected %b", i, out_cout, vc[i]); end
      checks++;
      if (out_ovf !== vo[i]) begin errors++; $display("FAIL dir%0d_ovf: got %b expected %b", i, out_ovf, vo[i]); end
      checks++;
      if (out_zero !== vz[i]) begin errors++; $display("FAIL dir%0d_zero: got %b expected %b", i, out_zero, vz[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_narrow;
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic [7:0] vs [5];
    logic [4:0] vsub, vcin, vc, vo, vz;
    int         lat;
    va   = '{8'hFF, 8'h80, 8'h7F, 8'hAA, 8'h03};
    vb   = '{8'h01, 8'h01, 8'h01, 8'h55, 8'h05};
    vs   = '{8'h00, 8'h7F, 8'h80, 8'h00, 8'hFE};
    vsub = 5'b10010;
    vcin = 5'b01000;
    vc   = 5'b01011;
    vo   = 5'b00110;
    vz   = 5'b01001;
    n_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_in_valid = 1'b1; n_in_a = va[i]; n_in_b = vb[i]; n_in_sub = vsub[i]; n_in_cin = vcin[i];
      lat = 0;
      do begin
        @(posedge clk); #1;
        n_in_valid = 1'b0;
        lat++;
      end while (n_out_valid !== 1'b1 && lat < 12);
      checks++;
      if (lat != 3) begin errors++; $display("FAIL narrow%0d_latency: got %0d expected 3", i, lat); end
      checks++;
      if ({n_out_cout, n_out_ovf, n_out_zero, n_out_sum} !== {vc[i], vo[i], vz[i], vs[i]}) begin
        errors++;
        $display("FAIL narrow%0d_result: got c=%b o=%b z=%b s=%h expected c=%b o=%b z=%b s=%h", i,
                 n_out_cout, n_out_ovf, n_out_zero, n_out_sum, vc[i], vo[i], vz[i], vs[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [34:0] expv [10];
    logic [34:0] obs;
    int          nv, bad_ready;
    logic [31:0] a, b;
    nv = 0; bad_ready = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      obs = {out_cout, out_ovf, out_zero, out_sum};
      if (in_ready !== 1'b1) bad_ready++;
      if (out_valid === 1'b1) begin
        checks++;
        if (nv != c - 4 || nv > 9) begin
          errors++; $display("FAIL b2b_timing: got beat %0d at cycle %0d expected cycle %0d", nv, c, nv + 4);
        end else if (obs !== expv[nv]) begin
          errors++; $display("FAIL b2b_beat%0d: got %h expected %h", nv, obs, expv[nv]);
        end
        nv++;
      end else if (c >= 4 && c <= 13) begin
        checks++; errors++;
        $display("FAIL b2b_gap: got out_valid=%b at cycle %0d expected 1", out_valid, c);
      end
      if (c < 10) begin
        a = 32'(c) * 32'h13579BDF;
        b = 32'hFFFFFFF0 + 32'(c);
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = c[0]; in_cin = c[1];
        expv[c] = model(a, b, c[0], c[1]);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (nv != 10) begin errors++; $display("FAIL b2b_count: got %0d expected 10", nv); end
    checks++;
    if (bad_ready != 0) begin errors++; $display("FAIL b2b_in_ready: got %0d low cycles expected 0", bad_ready); end
  endtask

  task automatic test_flow(input int n, input bit rnd);
    logic [34:0] expq [$];
    logic [34:0] obs, held, e;
    bit          was_stalled;
    int          sent, got, stall_cycles, first_pop, last_pop;
    logic [31:0] a, b;
    logic        s, ci;
    sent = 0; got = 0; stall_cycles = 0; was_stalled = 1'b0; held = '0;
    first_pop = -1; last_pop = -1;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 4000 && got < n; cyc++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'(cyc >= 9);
      #1;
      obs = {out_cout, out_ovf, out_zero, out_sum};
      if (was_stalled) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== held) begin
          errors++; $display("FAIL flow_hold: got v=%b %h expected v=1 %h", out_valid, obs, held);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b0) begin
        stall_cycles++;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flow_stall_in_ready: got %b expected 0", in_ready); end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL flow_extra: got beat %h expected none", obs);
        end else begin
          e = expq.pop_front();
          if (obs !== e) begin errors++; $display("FAIL flow_beat%0d: got %h expected %h", got, obs, e); end
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        got++;
      end
      was_stalled = (out_valid === 1'b1) && (out_ready === 1'b0);
      held = obs;
      if (in_ready === 1'b1 && sent < n) begin
        a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
        if (!rnd && sent == 0) begin a = 32'hAAAAAAAA; b = 32'h55555555; s = 1'b0; ci = 1'b1; end
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = s; in_cin = ci;
        expq.push_back(model(a, b, s, ci));
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != n || expq.size() != 0) begin
      errors++; $display("FAIL flow_count: got %0d beats (%0d pending) expected %0d", got, expq.size(), n);
    end
    if (!rnd) begin
      checks++;
      if (stall_cycles < 5) begin errors++; $display("FAIL flow_stall_len: got %0d expected >=5", stall_cycles); end
      checks++;
      if (last_pop - first_pop != n - 1) begin
        errors++; $display("FAIL flow_no_bubble: got span %0d expected %0d", last_pop - first_pop, n - 1);
      end
    end
  endtask

  task automatic test_reset_flush;
    int hits;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 32'(i + 1); in_b = 32'h100; in_sub = 1'b0; in_cin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    hits = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid !== 1'b0) hits++;
      @(posedge clk); #1;
    end
    checks++;
    if (hits != 0) begin errors++; $display("FAIL flush_emerged: got %0d valid cycles expected 0", hits); end

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 32'(i); in_b = 32'h7; in_sub = 1'b0; in_cin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_full: got v=%b rdy=%b expected v=1 rdy=0", out_valid, in_ready);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_reset_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    hits = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid !== 1'b0) hits++;
      @(posedge clk); #1;
    end
    checks++;
    if (hits != 0) begin errors++; $display("FAIL flush_full_emerged: got %0d valid cycles expected 0", hits); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_narrow();
    test_back_to_back();
    test_flow(8, 1'b0);
    test_flow(300, 1'b1);
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
